mux4_rr_sched: RTL and testbench
================================

// Module: mux4_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one 4:1 datapath mux between four requesters (a,b,c,d).
//  Picks a winner, drives the 2-bit mux select, and forwards the winner's word downstream
//  with a valid/ready handshake. Each requester may hold the path for at most MAX_BURST beats.
//  Sits between four producer ports and a single shared consumer port.
// PARAMETERS
//  DW         5   data width of each input word and of y
//  MAX_BURST  4   max accepted beats per grant (>=1); release is forced after this many
//  BCW        $clog2(MAX_BURST+1)  beat-counter width (derived, localparam)
// PORTS
//  clk      in   1    sole clock, rising edge
//  rst      in   1    synchronous, active-high reset
//  req      in   4    req[i]: requester i has a word on its data input (bit0=a .. bit3=d)
//  a,b,c,d  in   DW   requester data words; held stable while own req is high
//  y_ready  in   1    downstream can accept y this cycle
//  y        out  DW   forwarded word = mux(sel); forced 0 when y_valid=0
//  y_valid  out  1    y holds a valid beat
//  sel      out  2    registered mux select of the current/last grant
//  gnt      out  4    registered one-hot grant; 0 in IDLE
//  ack      out  4    ack[i] = gnt[i] & y_valid & y_ready (beat taken from requester i)
//  busy     out  1    state==GRANT
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, gnt=0, sel=0, ptr=0, beat=0; so y_valid=0, y=0, ack=0, busy=0.
//    Reset mid-burst abandons the grant immediately; no ack asserted in the reset cycle's output.
//  - FSM: IDLE, GRANT.
//    IDLE: if req!=0, winner = first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4);
//      next edge: gnt=onehot(winner), sel=winner, beat=0, state=GRANT. req==0 -> stay IDLE.
//    GRANT: y_valid = req[sel] (combinational); transfer = y_valid & y_ready.
//      transfer & beat==MAX_BURST-1 -> IDLE, gnt=0, ptr=sel+1 (wraps 3->0).
//      transfer otherwise -> beat=beat+1, stay GRANT.
//      req[sel]==0 -> IDLE, gnt=0, ptr=sel+1 (requester released early).
//      else hold (stalled by y_ready=0): no state change.
//  - Latency: req rising in IDLE -> gnt/y_valid one cycle later. Release always costs one IDLE
//    cycle before next grant (no back-to-back regrant; intended bubble).
//  - sel keeps its last value in IDLE; y gated to 0 so downstream never sees stale data.
//  - Requests from non-granted ports are ignored during GRANT; they must stay asserted.
//  - ptr is 2-bit, wraps naturally; beat never exceeds MAX_BURST-1.
//  - Fairness: any requester holding req is granted within 3 grants of others.
//  - MAX_BURST=1: every accepted beat releases the grant.
// STRUCTURE
//  - Shared package mux4_sched_pkg: state enum (IDLE=1'b0, GRANT=1'b1), NREQ=4, SELW=2.
//  - One combinational sub-module rr_pick4: inputs req[3:0], ptr[1:0];
//    outputs any, winner[1:0] (rotate-priority encoder). Mux and FSM stay in top.
// TESTING
//  1 Reset: drive rst=1 with req=4'hF -> gnt=0, y_valid=0, y=0, busy=0; after release ptr=0 ->
//    first grant goes to a (gnt=4'b0001, sel=0) one cycle later.
//  2 Single requester: req=4'b0100, c=5'h16, y_ready=1 -> gnt=4'b0100, y=5'h16, 4 acks,
//    then IDLE 1 cycle, regrant to c (only requester), ptr wrapped to 3 then picks 2.
//  3 Round robin: req=4'hF held, y_ready=1, MAX_BURST=4 -> grant order a,b,c,d,a; each 4 beats,
//    one idle cycle between grants.
//  4 Backpressure: grant b, y_ready=0 for 5 cycles -> y_valid=1, ack=0, beat unchanged,
//    gnt stable; y_ready=1 -> beats resume and count to 4.
//  5 Early release: grant d, drop req[3] after 2 acks -> next edge IDLE, ptr=0;
//    req=4'b1001 -> a wins next.
//  6 Reset mid-burst: assert rst during beat 2 of grant c -> next cycle gnt=0, y_valid=0, ptr=0.

Source files
------------

// File: rtl/mux4_sched_pkg.sv
// Shared types and constants for the four-way round-robin mux scheduler.
package mux4_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam int NREQ = 4;
   localparam int SELW = 2;

   function automatic logic [NREQ-1:0] onehot4(input logic [SELW-1:0] idx);
      logic [NREQ-1:0] v;
      v = 4'b0001 << idx;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotate-priority encoder: first set request bit starting at ptr, wrapping mod 4.
module rr_pick4
   import mux4_sched_pkg::*;
(
   input  logic [NREQ-1:0] req_i,
   input  logic [SELW-1:0] ptr_i,
   output logic            any_o,
   output logic [SELW-1:0] winner_o
);

   logic [2*NREQ-1:0] dbl_s;
   logic [NREQ-1:0]   rot_s;
   logic [SELW-1:0]   off_s;

   // Rotating the doubled vector puts requester ptr at bit 0.
   assign dbl_s = {req_i, req_i};
   assign rot_s = dbl_s[ptr_i +: NREQ];

   // Offset of the first pending request from ptr.
   always_comb begin
      off_s = 2'd0;
      casez (rot_s)
         4'b???1: off_s = 2'd0;
         4'b??10: off_s = 2'd1;
         4'b?100: off_s = 2'd2;
         4'b1000: off_s = 2'd3;
         default: off_s = 2'd0;
      endcase
   end

   assign any_o    = |req_i;
   assign winner_o = ptr_i + off_s;

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one 4:1 data mux between four requesters,
// with per-grant burst limit and a valid/ready downstream handshake.
module mux4_rr_sched
   import mux4_sched_pkg::*;
#(
   parameter int DW        = 5,
   parameter int MAX_BURST = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [3:0]      req_i,
   input  logic [DW-1:0]   a_i,
   input  logic [DW-1:0]   b_i,
   input  logic [DW-1:0]   c_i,
   input  logic [DW-1:0]   d_i,
   input  logic            y_ready_i,
   output logic [DW-1:0]   y_o,
   output logic            y_valid_o,
   output logic [1:0]      sel_o,
   output logic [3:0]      gnt_o,
   output logic [3:0]      ack_o,
   output logic            busy_o
);

   localparam int             BCW       = $clog2(MAX_BURST + 1);
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);
   localparam logic [BCW-1:0] BEAT_ONE  = BCW'(1);
   localparam logic [BCW-1:0] BEAT_ZERO = BCW'(0);

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic [BCW-1:0]  beat_q, beat_d;

   logic            any_s;
   logic [SELW-1:0] winner_s;
   logic [DW-1:0]   mux_s;
   logic            y_valid_s;
   logic            xfer_s;

   rr_pick4 u_pick (
      .req_i    (req_i),
      .ptr_i    (ptr_q),
      .any_o    (any_s),
      .winner_o (winner_s)
   );

   // The shared datapath mux, steered by the registered select.
   always_comb begin
      mux_s = a_i;
      case (sel_q)
         2'd0:    mux_s = a_i;
         2'd1:    mux_s = b_i;
         2'd2:    mux_s = c_i;
         2'd3:    mux_s = d_i;
         default: mux_s = a_i;
      endcase
   end

   assign y_valid_s = (state_q == GRANT) & req_i[sel_q];
   assign xfer_s    = y_valid_s & y_ready_i;

   // y is gated so a stale select in IDLE never leaks data downstream.
   assign y_o       = y_valid_s ? mux_s : {DW{1'b0}};
   assign y_valid_o = y_valid_s;
   assign sel_o     = sel_q;
   assign gnt_o     = gnt_q;
   assign ack_o     = gnt_q & {NREQ{xfer_s}};
   assign busy_o    = (state_q == GRANT);

   // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (any_s) begin
               state_d = GRANT;
               gnt_d   = onehot4(winner_s);
               sel_d   = winner_s;
               beat_d  = BEAT_ZERO;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if ((xfer_s && (beat_q == LAST_BEAT)) || !req_i[sel_q]) begin
               state_d = IDLE;
               gnt_d   = 4'b0000;
               ptr_d   = sel_q + 2'd1;
               beat_d  = BEAT_ZERO;
            end else if (xfer_s) begin
               beat_d  = beat_q + BEAT_ONE;
            end else begin
               state_d = GRANT;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd0;
         beat_q  <= BEAT_ZERO;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         beat_q  <= beat_d;
      end
   end

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed self-checking bench for mux4_rr_sched (DW=5, MAX_BURST=4).
module tb_mux4_rr_sched;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [4:0] a, b, c, d;
   logic       y_ready;
   logic [4:0] y;
   logic       y_valid;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic [3:0] ack;
   logic       busy;

   int n_total = 0;
   int n_bad   = 0;

   logic [4:0] dat [4];

   mux4_rr_sched #(.DW(5), .MAX_BURST(4)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .a_i       (a),
      .b_i       (b),
      .c_i       (c),
      .d_i       (d),
      .y_ready_i (y_ready),
      .y_o       (y),
      .y_valid_o (y_valid),
      .sel_o     (sel),
      .gnt_o     (gnt),
      .ack_o     (ack),
      .busy_o    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance past the next rising edge, then let inputs/outputs settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full burst from requester w: four acks, then the idle bubble.
   task automatic burst4(input int w, input string tag);
      logic [3:0] oh;
      oh = 4'b0001 << w;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk({tag, "_gnt"}, {4'h0, gnt}, {4'h0, oh});
         chk({tag, "_y"},   {3'b000, y}, {3'b000, dat[w]});
         chk({tag, "_ack"}, {4'h0, ack}, {4'h0, oh});
         tick();
      end
      #1;
      chk({tag, "_bubble_gnt"}, {4'h0, gnt}, 8'h00);
      chk({tag, "_bubble_vld"}, {7'h00, y_valid}, 8'h00);
   endtask

   initial begin
      a = 5'h0A; b = 5'h0B; c = 5'h16; d = 5'h1D;
      dat[0] = 5'h0A; dat[1] = 5'h0B; dat[2] = 5'h16; dat[3] = 5'h1D;
      rst = 1'b1; req = 4'hF; y_ready = 1'b1;

      // 1 reset with all requests pending
      tick(); tick();
      chk("rst_gnt",  {4'h0, gnt},       8'h00);
      chk("rst_vld",  {7'h00, y_valid},  8'h00);
      chk("rst_y",    {3'b000, y},       8'h00);
      chk("rst_busy", {7'h00, busy},     8'h00);
      chk("rst_ack",  {4'h0, ack},       8'h00);
      rst = 1'b0;
      tick();
      chk("first_gnt", {4'h0, gnt},   8'h01);
      chk("first_sel", {6'h00, sel},  8'h00);
      chk("first_y",   {3'b000, y},   8'h0A);
      req = 4'h0;
      #1;
      chk("drop_vld", {7'h00, y_valid}, 8'h00);
      tick();
      chk("drop_busy", {7'h00, busy}, 8'h00);

      // 2 single requester c, ptr now 1
      req = 4'b0100;
      tick();
      burst4(2, "single");
      chk("single_sel_kept", {6'h00, sel}, 8'h02);
      chk("single_y_gated",  {3'b000, y},  8'h00);
      tick();
      chk("single_regrant", {4'h0, gnt}, 8'h04);
      req = 4'h0;
      tick();

      // 3 round robin from a fresh pointer
      rst = 1'b1;
      tick();
      rst = 1'b0; req = 4'hF;
      tick();
      for (int g = 0; g < 5; g++) begin
         burst4(g % 4, "rr");
         if (g < 4) tick();
      end
      req = 4'h0;
      tick();

      // 4 backpressure on b (ptr is 1)
      req = 4'b0010;
      tick();
      y_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_vld", {7'h00, y_valid}, 8'h01);
         chk("bp_ack", {4'h0, ack},      8'h00);
         chk("bp_gnt", {4'h0, gnt},      8'h02);
         tick();
      end
      y_ready = 1'b1;
      burst4(1, "bp_resume");
      req = 4'h0;

      // 5 early release of d (ptr is 2, scan reaches 3)
      req = 4'b1000;
      tick();
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("early_ack", {4'h0, ack}, 8'h08);
         tick();
      end
      req = 4'h0;
      #1;
      chk("early_drop_ack", {4'h0, ack}, 8'h00);
      tick();
      chk("early_idle_gnt",  {4'h0, gnt},   8'h00);
      chk("early_idle_busy", {7'h00, busy}, 8'h00);
      req = 4'b1001;
      tick();
      chk("early_next_gnt", {4'h0, gnt},  8'h01);
      chk("early_next_sel", {6'h00, sel}, 8'h00);
      req = 4'h0;
      tick();

      // 6 reset during beat 2 of grant c (ptr is 1)
      req = 4'b0100;
      tick();
      tick(); tick();
      chk("mid_beat2_ack", {4'h0, ack}, 8'h04);
      rst = 1'b1;
      tick();
      chk("mid_rst_gnt",  {4'h0, gnt},      8'h00);
      chk("mid_rst_vld",  {7'h00, y_valid}, 8'h00);
      chk("mid_rst_ack",  {4'h0, ack},      8'h00);
      chk("mid_rst_busy", {7'h00, busy},    8'h00);
      rst = 1'b0; req = 4'hF;
      tick();
      chk("mid_ptr0_gnt", {4'h0, gnt}, 8'h01);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
